pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// PipeCtrl (module pipe_ctrl) - pipeline hazard / hold / flush controller
//
// Watches the decode and execute stages and produces the per-stage hold
// vector, the pipeline flush strobe and the multi-cycle completion pulse.
// It also counts the load-use stall cycles it has inserted.
//
// Ports
//   clk             pipeline clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   id_reg1_read    decode stage reads register port 1
//   id_reg1_addr    decode stage register port 1 address (5 bits)
//   id_reg2_read    decode stage reads register port 2
//   id_reg2_addr    decode stage register port 2 address (5 bits)
//   ex_is_load      execute-stage instruction is a load
//   ex_wreg         execute-stage instruction writes a register
//   ex_wd           execute-stage destination register (5 bits)
//   mc_start        execute stage begins a multi-cycle operation
//   mc_cycles       total hold cycles N of that operation (6 bits)
//   flush_req       request to flush the pipeline
//   stall           hold vector {WB,MEM,EX,ID,IF,PC}, 1 = hold stage
//   flush           clear all pipeline registers this cycle
//   mc_done         pulse in the last hold cycle of a multi-cycle operation
//   load_stall_cnt  saturating count of load-use stall cycles (16 bits)
// ---------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read,
  input  logic        id_reg2_read,
  input  logic [4:0]  id_reg1_addr,
  input  logic [4:0]  id_reg2_addr,
  input  logic        ex_is_load,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_wd,
  input  logic        mc_start,
  input  logic [5:0]  mc_cycles,
  input  logic        flush_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        mc_done,
  output logic [15:0] load_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MC    = 2'd1,
    S_FLUSH = 2'd2
  } stateT;

  // Hold patterns: a held stage always holds every earlier stage too.
  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [5:0] STALL_MC       = 6'b001111;

  stateT       r_state;
  logic [5:0]  r_cnt;
  logic [15:0] r_loadStallCnt;
  logic        w_hazard;

  // A load in EX whose result is needed by the instruction in ID.
  // Register 0 is never a real dependency.
  assign w_hazard = ex_is_load && ex_wreg && (ex_wd != 5'd0) &&
                    ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                     (id_reg2_read && (id_reg2_addr == ex_wd)));

  assign load_stall_cnt = r_loadStallCnt;

  // State, hold counter and stall statistics. r_cnt holds the number of
  // remaining hold cycles in S_MC, including the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 6'd0;
      r_loadStallCnt <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_state <= S_FLUSH;
            r_cnt   <= 6'd0;
          end else if (mc_start) begin
            // N of 0 or 1 completes without leaving S_IDLE.
            if (mc_cycles >= 6'd2) begin
              r_state <= S_MC;
              r_cnt   <= mc_cycles - 6'd1;
            end
          end else if (w_hazard) begin
            if (r_loadStallCnt != 16'hFFFF)
              r_loadStallCnt <= r_loadStallCnt + 16'd1;
          end
        end
        S_MC: begin
          if (flush_req) begin
            r_state <= S_FLUSH;
            r_cnt   <= 6'd0;
          end else if (r_cnt == 6'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_FLUSH: begin
          r_cnt <= 6'd0;
          if (flush_req)
            r_state <= S_FLUSH;
          else
            r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

  // Outputs must react in the same cycle as the hazard or mc_start, so they
  // are decoded from the current state and inputs rather than registered.
  always_comb begin
    stall   = 6'b000000;
    flush   = 1'b0;
    mc_done = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            stall = 6'b000000;
          end else if (mc_start) begin
            if (mc_cycles != 6'd0)
              stall = STALL_MC;
            if (mc_cycles == 6'd1)
              mc_done = 1'b1;
          end else if (w_hazard) begin
            stall = STALL_LOAD_USE;
          end
        end
        S_MC: begin
          stall = STALL_MC;
          // A flush arriving in the last hold cycle aborts the operation.
          if (!flush_req && (r_cnt == 6'd1))
            mc_done = 1'b1;
        end
        S_FLUSH: begin
          flush = 1'b1;
        end
        default: begin
          stall = 6'b000000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl - directed self-checking bench for pipe_ctrl
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_reg1_read;
  logic        id_reg2_read;
  logic [4:0]  id_reg1_addr;
  logic [4:0]  id_reg2_addr;
  logic        ex_is_load;
  logic        ex_wreg;
  logic [4:0]  ex_wd;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        flush_req;
  logic [5:0]  stall;
  logic        flush;
  logic        mc_done;
  logic [15:0] load_stall_cnt;

  int checkCount;
  int errorCount;
  int expLsc;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read   (id_reg1_read),
    .id_reg2_read   (id_reg2_read),
    .id_reg1_addr   (id_reg1_addr),
    .id_reg2_addr   (id_reg2_addr),
    .ex_is_load     (ex_is_load),
    .ex_wreg        (ex_wreg),
    .ex_wd          (ex_wd),
    .mc_start       (mc_start),
    .mc_cycles      (mc_cycles),
    .flush_req      (flush_req),
    .stall          (stall),
    .flush          (flush),
    .mc_done        (mc_done),
    .load_stall_cnt (load_stall_cnt)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [5:0] expStall,
                          input logic expFlush, input logic expDone);
    checkOutput({tag, ".stall"}, {26'd0, stall}, {26'd0, expStall});
    checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, expFlush});
    checkOutput({tag, ".mc_done"}, {31'd0, mc_done}, {31'd0, expDone});
  endtask

  task automatic checkLsc(input string tag);
    checkOutput({tag, ".load_stall_cnt"}, {16'd0, load_stall_cnt}, expLsc);
  endtask

  task automatic applyStimulus(input logic r1Rd, input logic [4:0] a1,
                               input logic r2Rd, input logic [4:0] a2,
                               input logic isLoad, input logic wreg,
                               input logic [4:0] wd, input logic mcStart,
                               input logic [5:0] mcCyc, input logic flushReq);
    id_reg1_read = r1Rd;
    id_reg1_addr = a1;
    id_reg2_read = r2Rd;
    id_reg2_addr = a2;
    ex_is_load   = isLoad;
    ex_wreg      = wreg;
    ex_wd        = wd;
    mc_start     = mcStart;
    mc_cycles    = mcCyc;
    flush_req    = flushReq;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0);
  endtask

  // Inputs change 1 unit after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    expLsc     = 0;

    // Reset with activity on every input: outputs must stay quiet
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 6'd1, 1'b0);
    @(negedge clk);
    checkAll("reset", 6'h00, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkAll("resetHeld", 6'h00, 1'b0, 1'b0);
    checkLsc("reset");
    nextCycle();
    rst = 1'b0;
    clearInputs();

    // Load-use hazard on port 2
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checkAll("hazard2", 6'h07, 1'b0, 1'b0);
    checkLsc("hazard2Before");
    nextCycle();
    expLsc = 1;
    clearInputs();
    @(negedge clk);
    checkAll("hazard2After", 6'h00, 1'b0, 1'b0);
    checkLsc("hazard2After");

    // Destination r0 is never a hazard
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checkAll("wdZero", 6'h00, 1'b0, 1'b0);
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkLsc("wdZero");

    // Hazard on port 1
    nextCycle();
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checkAll("hazard1", 6'h07, 1'b0, 1'b0);
    nextCycle();
    expLsc = 2;
    // Port 1 not read: no hazard
    applyStimulus(1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checkAll("noRead", 6'h00, 1'b0, 1'b0);
    checkLsc("hazard1");
    nextCycle();
    // Load that does not write a register: no hazard
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checkAll("noWreg", 6'h00, 1'b0, 1'b0);
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkLsc("noHazardCases");

    // Multi-cycle N=4: four hold cycles, done in the fourth
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd4, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checkAll($sformatf("mc4.c%0d", i), (i <= 4) ? 6'h0F : 6'h00, 1'b0,
               (i == 4));
      nextCycle();
      if (i == 1) clearInputs();
    end

    // N=1: single hold cycle with done
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd1, 1'b0);
    @(negedge clk);
    checkAll("mc1", 6'h0F, 1'b0, 1'b1);
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkAll("mc1After", 6'h00, 1'b0, 1'b0);

    // N=0: nothing happens
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    @(negedge clk);
    checkAll("mc0", 6'h00, 1'b0, 1'b0);
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkAll("mc0After", 6'h00, 1'b0, 1'b0);

    // N=10 flushed in its third hold cycle
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd10, 1'b0);
    @(negedge clk);
    checkAll("mcFl.c1", 6'h0F, 1'b0, 1'b0);
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkAll("mcFl.c2", 6'h0F, 1'b0, 1'b0);
    nextCycle();
    flush_req = 1'b1;
    @(negedge clk);
    checkAll("mcFl.c3", 6'h0F, 1'b0, 1'b0);
    nextCycle();
    flush_req = 1'b0;
    @(negedge clk);
    checkAll("mcFl.c4", 6'h00, 1'b1, 1'b0);
    for (int i = 5; i <= 14; i++) begin
      nextCycle();
      @(negedge clk);
      checkAll($sformatf("mcFl.c%0d", i), 6'h00, 1'b0, 1'b0);
    end

    // flush_req and mc_start together in S_IDLE: flush wins
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd5, 1'b1);
    @(negedge clk);
    checkAll("flMc.req", 6'h00, 1'b0, 1'b0);
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkAll("flMc.flush", 6'h00, 1'b1, 1'b0);
    checkOutput("flMc.cnt", {26'd0, dut.r_cnt}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkAll("flMc.after", 6'h00, 1'b0, 1'b0);

    // mc_start with a hazard (N=3): hazard ignored, count unchanged
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 6'd3, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkAll($sformatf("mcHz.c%0d", i), 6'h0F, 1'b0, (i == 3));
      nextCycle();
    end
    clearInputs();
    @(negedge clk);
    checkAll("mcHz.after", 6'h00, 1'b0, 1'b0);
    checkLsc("mcHz");

    // Reset during S_MC aborts silently
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd8, 1'b0);
    nextCycle();
    clearInputs();
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkAll("rstMc.during", 6'h00, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
    expLsc = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkAll($sformatf("rstMc.after%0d", i), 6'h00, 1'b0, 1'b0);
      nextCycle();
    end
    checkLsc("rstMc");
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd2, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkAll($sformatf("mc2.c%0d", i), (i <= 2) ? 6'h0F : 6'h00, 1'b0,
               (i == 2));
      nextCycle();
      if (i == 1) clearInputs();
    end

    // Reset during S_FLUSH: no flush pulse after the reset edge
    flush_req = 1'b1;
    nextCycle();
    flush_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkAll("rstFl.during", 6'h00, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkAll("rstFl.after", 6'h00, 1'b0, 1'b0);

    // Saturation: 65534 + 3 load-use stall cycles
    nextCycle();
    applyStimulus(1'b1, 5'd12, 1'b0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b0, 6'd0, 1'b0);
    for (int k = 1; k <= 65537; k++) begin
      nextCycle();
      if (k == 65534) begin
        expLsc = 65534;
        checkLsc("sat.preload");
      end
    end
    clearInputs();
    expLsc = 65535;
    @(negedge clk);
    checkLsc("sat.final");

    // Reset with hazard and mc_start present clears the count
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 5'd12, 1'b0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 6'd1, 1'b0);
    @(negedge clk);
    checkAll("satRst.during", 6'h00, 1'b0, 1'b0);
    nextCycle();
    expLsc = 0;
    @(negedge clk);
    checkAll("satRst.after", 6'h00, 1'b0, 1'b0);
    checkLsc("satRst");
    rst = 1'b0;
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
